idea_a_checker: RTL
===================

// Module: idea_a_checker
// PURPOSE
//  Receive-side companion to the IdeaA 4-bit code sequencer: samples its VAL code each clock, decodes it
//  to a BCD digit, verifies each cycle is a hold or one legal step, locks onto the stream, flags errors.
//  Legal cycle (generator order): 0111,0110,0101,1110,1101,1100,1011,1010,1001,1000, then 0111.
//  Decoded digits: 9,8,7,6,5,4,3,2,1,0. 0000 = generator reset code, next 0111. 0001-0100, 1111 = illegal.
// PARAMETERS
//  LOCK_STEPS  2  consecutive legal steps in ACQUIRE before LOCKED (1..7)
//  CNT_W       8  width of WRAP_CNT and ERR_CNT (saturating)
// PORTS
//  C1K         in   1      clock, rising edge; sole clock
//  RST         in   1      reset, synchronous, active-low
//  CODE        in   4      code from sequencer VAL
//  DIGIT       out  4      decoded BCD digit of last sampled code; 0 unless DIGIT_VALID
//  DIGIT_VALID out  1      high while LOCKED
//  STEP        out  1      1-cycle pulse: legal step accepted in LOCKED
//  WRAP        out  1      1-cycle pulse: LOCKED step 1000->0111 (digit 0->9)
//  ERR         out  1      1-cycle pulse: sequence violation (see below)
//  WRAP_CNT    out  CNT_W  saturating count of WRAP pulses
//  ERR_CNT     out  CNT_W  saturating count of ERR pulses
//  LOG_STATE   out  2      FSM state: 0 IDLE, 1 ACQUIRE, 2 LOCKED, 3 ERROR
// BEHAVIOUR
//  - All outputs registered; CODE sampled at edge k is reflected in outputs after edge k (1-cycle latency).
//  - prev register holds code sampled at edge k-1. Per edge, classify CODE vs prev:
//    HOLD = equal; NEXT = successor of prev (0000->0111 counts as NEXT); ZERO = 0000;
//    ILL = illegal code; JUMP = legal, non-ZERO, neither HOLD nor NEXT.
//  - Reset (RST=0 at edge): state IDLE, prev=0000, acquire count 0, all outputs 0, counters 0.
//    Reset wins over every other event, including mid-LOCKED.
//  - IDLE:    legal non-zero -> ACQUIRE (cnt=0); ZERO stays; ILL -> ERROR, ERR pulse.
//  - ACQUIRE: HOLD stays; NEXT cnt++, -> LOCKED when cnt reaches LOCK_STEPS; JUMP restarts ACQUIRE
//    (cnt=0, no ERR); ZERO -> IDLE; ILL -> ERROR, ERR pulse.
//  - LOCKED:  HOLD stays, no STEP; NEXT -> STEP pulse (+WRAP pulse same cycle on 1000->0111);
//    JUMP -> ERR pulse, ACQUIRE cnt=0; ILL -> ERR pulse, ERROR; ZERO -> IDLE, no ERR.
//  - ERROR:   ILL stays, no repeat ERR; legal non-zero -> ACQUIRE cnt=0; ZERO -> IDLE.
//  - Counters increment by 1 on their pulse; hold at all-ones (no wrap).
//  - DIGIT/DIGIT_VALID valid in the cycle LOCKED is entered; forced 0 in any other state.
//  - prev updated every non-reset edge, including illegal codes.
// STRUCTURE
//  - Shared include libs/IdeaA_codes.vh: `define per legal code, reset code, state encodings; the
//    IdeaA sequencer and this block both use it.
//  - One sub-module: idea_a_code_rom (combinational): code -> {legal, zero, digit[3:0], next_code[3:0]}.
//    Instanced twice (CODE and prev) or once on prev with a separate CODE classifier.
//  - Top: FSM, prev/cnt registers, saturating counters, output registers.
// TESTING
//  1 RST=0 two edges, CODE=0111 -> all outputs 0, LOG_STATE=0; RST=1 -> ACQUIRE next edge.
//  2 CODE 0000,0111,0110,0101 one per cycle -> LOCKED after 0101, DIGIT=7, DIGIT_VALID=1; 0101 held 3
//    cycles -> no STEP.
//  3 Continue legal stream to 1000 then 0111 -> STEP every cycle, WRAP once with DIGIT 0->9, WRAP_CNT=1.
//  4 LOCKED at 1100 (digit 4), drive 1010 -> ERR 1 cycle, ERR_CNT=1, LOG_STATE=1, DIGIT_VALID=0.
//  5 LOCKED, drive 0011 held 3 cycles -> one ERR, LOG_STATE=3; then 1001 -> ACQUIRE; 0000 -> IDLE, no ERR.
//  6 CNT_W=2: force 5 JUMPs in LOCKED -> ERR_CNT=3, saturated; RST=0 mid-LOCKED -> counters 0 next edge.

Source files
------------

// File: rtl/idea_a_checker_pkg.sv
// Shared definitions for the IdeaA receive-side checker.
//   - FSM state encoding (matches the LOG_STATE output values)
//   - IdeaA code points: nine-to-zero digit codes plus the generator reset code
//   - code_class / code_succ: decode helpers used by the code ROM and the top
package idea_a_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_ERROR   = 2'd3
  } state_e;

  localparam logic [3:0] CODE_RESET = 4'b0000;
  localparam logic [3:0] CODE_D9    = 4'b0111;
  localparam logic [3:0] CODE_D8    = 4'b0110;
  localparam logic [3:0] CODE_D7    = 4'b0101;
  localparam logic [3:0] CODE_D6    = 4'b1110;
  localparam logic [3:0] CODE_D5    = 4'b1101;
  localparam logic [3:0] CODE_D4    = 4'b1100;
  localparam logic [3:0] CODE_D3    = 4'b1011;
  localparam logic [3:0] CODE_D2    = 4'b1010;
  localparam logic [3:0] CODE_D1    = 4'b1001;
  localparam logic [3:0] CODE_D0    = 4'b1000;

  // legal: one of the ten digit codes; zero: the generator reset code.
  // Anything with neither bit set is illegal.
  typedef struct packed {
    logic       legal;
    logic       zero;
    logic [3:0] digit;
  } code_class_t;

  function automatic code_class_t code_class(input logic [3:0] code);
    code_class_t c;
    c = '0;
    unique case (code)
      CODE_RESET: c.zero = 1'b1;
      CODE_D9:    c = '{legal: 1'b1, zero: 1'b0, digit: 4'd9};
      CODE_D8:    c = '{legal: 1'b1, zero: 1'b0, digit: 4'd8};
      CODE_D7:    c = '{legal: 1'b1, zero: 1'b0, digit: 4'd7};
      CODE_D6:    c = '{legal: 1'b1, zero: 1'b0, digit: 4'd6};
      CODE_D5:    c = '{legal: 1'b1, zero: 1'b0, digit: 4'd5};
      CODE_D4:    c = '{legal: 1'b1, zero: 1'b0, digit: 4'd4};
      CODE_D3:    c = '{legal: 1'b1, zero: 1'b0, digit: 4'd3};
      CODE_D2:    c = '{legal: 1'b1, zero: 1'b0, digit: 4'd2};
      CODE_D1:    c = '{legal: 1'b1, zero: 1'b0, digit: 4'd1};
      CODE_D0:    c = '{legal: 1'b1, zero: 1'b0, digit: 4'd0};
      default:    c = '0;
    endcase
    return c;
  endfunction

  // Generator successor. Illegal codes have no successor; they return the
  // reset code, and callers gate the compare with legal|zero.
  function automatic logic [3:0] code_succ(input logic [3:0] code);
    logic [3:0] n;
    unique case (code)
      CODE_RESET: n = CODE_D9;
      CODE_D9:    n = CODE_D8;
      CODE_D8:    n = CODE_D7;
      CODE_D7:    n = CODE_D6;
      CODE_D6:    n = CODE_D5;
      CODE_D5:    n = CODE_D4;
      CODE_D4:    n = CODE_D3;
      CODE_D3:    n = CODE_D2;
      CODE_D2:    n = CODE_D1;
      CODE_D1:    n = CODE_D0;
      CODE_D0:    n = CODE_D9;
      default:    n = CODE_RESET;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/idea_a_code_rom.sv
// Combinational IdeaA code ROM.
//   code      in  4  code to decode
//   legal     out 1  code is one of the ten digit codes
//   zero      out 1  code is the generator reset code
//   digit     out 4  BCD digit (0 when not legal)
//   next_code out 4  generator successor of code
module idea_a_code_rom
  import idea_a_checker_pkg::*;
(
  input  logic [3:0] code,
  output logic       legal,
  output logic       zero,
  output logic [3:0] digit,
  output logic [3:0] next_code
);

  code_class_t cls;

  always_comb begin
    cls       = code_class(code);
    legal     = cls.legal;
    zero      = cls.zero;
    digit     = cls.digit;
    next_code = code_succ(code);
  end

endmodule

// File: rtl/idea_a_checker.sv
// IdeaA receive-side checker: samples the sequencer code every clock,
// decodes it to a BCD digit, checks each cycle is a hold or one legal step,
// locks onto the stream and flags sequence violations.
//   C1K         in   clock (rising edge)
//   RST         in   synchronous active-low reset
//   CODE        in   4-bit code from the sequencer
//   DIGIT       out  decoded digit of the last code, 0 unless DIGIT_VALID
//   DIGIT_VALID out  high while LOCKED
//   STEP        out  pulse: legal step accepted while LOCKED
//   WRAP        out  pulse: LOCKED step from digit 0 back to digit 9
//   ERR         out  pulse: sequence violation
//   WRAP_CNT    out  saturating WRAP count
//   ERR_CNT     out  saturating ERR count
//   LOG_STATE   out  FSM state (0 IDLE, 1 ACQUIRE, 2 LOCKED, 3 ERROR)
// All outputs are registered: CODE sampled at an edge shows up right after it.
module idea_a_checker
  import idea_a_checker_pkg::*;
#(
  parameter int LOCK_STEPS = 2,
  parameter int CNT_W      = 8
) (
  input  logic             C1K,
  input  logic             RST,
  input  logic [3:0]       CODE,
  output logic [3:0]       DIGIT,
  output logic             DIGIT_VALID,
  output logic             STEP,
  output logic             WRAP,
  output logic             ERR,
  output logic [CNT_W-1:0] WRAP_CNT,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic [1:0]       LOG_STATE
);

  localparam logic [2:0]       LOCK_C  = 3'(LOCK_STEPS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [3:0]       prev_q, prev_d;
  logic [3:0]       digit_q, digit_d;
  logic             digit_valid_q, digit_valid_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // ---- decode: ROM on prev, package classifier on the live code ----
  logic        prev_legal, prev_zero;
  logic [3:0]  prev_digit, prev_next;
  code_class_t code_cls;

  idea_a_code_rom u_rom_prev (
    .code      (prev_q),
    .legal     (prev_legal),
    .zero      (prev_zero),
    .digit     (prev_digit),
    .next_code (prev_next)
  );

  assign code_cls = code_class(CODE);

  // Classes are checked in priority order ILL, ZERO, HOLD, NEXT, JUMP so an
  // illegal code held in ERROR never reads as HOLD.
  logic is_ill, is_zero, is_hold, is_next, is_jump, is_wrap_step;

  always_comb begin
    is_ill       = !code_cls.legal && !code_cls.zero;
    is_zero      = code_cls.zero;
    is_hold      = (CODE == prev_q);
    is_next      = (prev_legal || prev_zero) && (CODE == prev_next);
    is_jump      = !is_ill && !is_zero && !is_hold && !is_next;
    is_wrap_step = prev_legal && (prev_digit == 4'd0);
  end

  // ---- state register ----
  always_ff @(posedge C1K) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      prev_q  <= CODE_RESET;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prev_d  = CODE;
    unique case (state_q)
      ST_IDLE: begin
        if (is_ill) begin
          state_d = ST_ERROR;
        end else if (!is_zero) begin
          state_d = ST_ACQUIRE;
          cnt_d   = '0;
        end
      end
      ST_ACQUIRE: begin
        if (is_ill) begin
          state_d = ST_ERROR;
        end else if (is_zero) begin
          state_d = ST_IDLE;
        end else if (is_hold) begin
          state_d = ST_ACQUIRE;
        end else if (is_next) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q + 3'd1 == LOCK_C) state_d = ST_LOCKED;
        end else begin
          // A jump before lock just restarts acquisition from this code.
          cnt_d = '0;
        end
      end
      ST_LOCKED: begin
        if (is_ill) begin
          state_d = ST_ERROR;
        end else if (is_zero) begin
          state_d = ST_IDLE;
        end else if (is_jump) begin
          state_d = ST_ACQUIRE;
          cnt_d   = '0;
        end
      end
      ST_ERROR: begin
        if (is_zero) begin
          state_d = ST_IDLE;
        end else if (!is_ill) begin
          state_d = ST_ACQUIRE;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---- output logic (registered below) ----
  always_comb begin
    step_d = 1'b0;
    err_d  = 1'b0;
    unique case (state_q)
      ST_IDLE:    err_d = is_ill;
      ST_ACQUIRE: err_d = is_ill;
      ST_LOCKED: begin
        err_d  = is_ill || is_jump;
        step_d = !is_ill && !is_zero && !is_hold && is_next;
      end
      ST_ERROR:   err_d = 1'b0;
      default:    err_d = 1'b0;
    endcase
    wrap_d        = step_d && is_wrap_step;
    digit_valid_d = (state_d == ST_LOCKED);
    digit_d       = digit_valid_d ? code_cls.digit : 4'd0;

    wrap_cnt_d = wrap_cnt_q;
    if (wrap_d && wrap_cnt_q != CNT_MAX) wrap_cnt_d = wrap_cnt_q + CNT_ONE;
    err_cnt_d = err_cnt_q;
    if (err_d && err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + CNT_ONE;
  end

  always_ff @(posedge C1K) begin
    if (!RST) begin
      digit_q       <= '0;
      digit_valid_q <= 1'b0;
      step_q        <= 1'b0;
      wrap_q        <= 1'b0;
      err_q         <= 1'b0;
      wrap_cnt_q    <= '0;
      err_cnt_q     <= '0;
    end else begin
      digit_q       <= digit_d;
      digit_valid_q <= digit_valid_d;
      step_q        <= step_d;
      wrap_q        <= wrap_d;
      err_q         <= err_d;
      wrap_cnt_q    <= wrap_cnt_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign DIGIT       = digit_q;
  assign DIGIT_VALID = digit_valid_q;
  assign STEP        = step_q;
  assign WRAP        = wrap_q;
  assign ERR         = err_q;
  assign WRAP_CNT    = wrap_cnt_q;
  assign ERR_CNT     = err_cnt_q;
  assign LOG_STATE   = state_q;

endmodule
